// File: rtl/cond_pkg.sv
// Shared types for the execute-stage condition unit.
// Condition codes, flag-write bit indices and flush FSM states.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    AL = 4'b1110
  } cond_t;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_C  = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/conditional_check.sv
// Evaluates a 4-bit condition code against the NZC flags.
// Unsupported codes never pass.
module conditional_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       c,
  input  logic       n,
  input  logic       z,
  output logic       cond_ex
);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      EQ:      cond_ex = z;
      NE:      cond_ex = ~z;
      CS:      cond_ex = c;
      CC:      cond_ex = ~c;
      MI:      cond_ex = n;
      PL:      cond_ex = ~n;
      AL:      cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage condition unit: NZC flags, write gating and
// the wrong-path flush sequence after a taken branch.
module cond_exec_stage
  import cond_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic       stall_i,
  input  logic [3:0] cond_i,
  input  logic [1:0] flag_w_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       pcs_i,
  input  logic       alu_n_i,
  input  logic       alu_z_i,
  input  logic       alu_c_i,
  output logic       reg_we_o,
  output logic       mem_we_o,
  output logic       pc_src_o,
  output logic       flush_o,
  output logic [2:0] flags_o
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  flush_state_t  state;
  flush_state_t  state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic n;
  logic z;
  logic c;
  logic cond_ex;
  logic live;
  logic fire;

  conditional_check u_check (
    .cond    (cond_i),
    .c       (c),
    .n       (n),
    .z       (z),
    .cond_ex (cond_ex)
  );

  // Reset outranks everything, so it also masks the write enables.
  assign live = valid_i & ~stall_i & ~rst & (state == IDLE);
  assign fire = live & cond_ex;

  always_comb begin
    reg_we_o = fire & reg_w_i;
    mem_we_o = fire & mem_w_i;
    pc_src_o = fire & pcs_i;
  end

  assign flags_o = {n, z, c};

  always_ff @(posedge clk) begin
    if (rst) begin
      n <= 1'b0;
      z <= 1'b0;
      c <= 1'b0;
    end else if (fire) begin
      if (flag_w_i[FLAGW_NZ]) begin
        n <= alu_n_i;
        z <= alu_z_i;
      end
      if (flag_w_i[FLAGW_C]) begin
        c <= alu_c_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flush_o   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pc_src_o) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        flush_o = ~rst;
        if (!stall_i) begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - CW'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed scoreboard bench for cond_exec_stage: driver queues
// hand-computed expectations, a negedge monitor pops and compares.
module tb_cond_exec_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic       stall_i;
  logic [3:0] cond_i;
  logic [1:0] flag_w_i;
  logic       reg_w_i;
  logic       mem_w_i;
  logic       pcs_i;
  logic       alu_n_i;
  logic       alu_z_i;
  logic       alu_c_i;
  logic       reg_we_o;
  logic       mem_we_o;
  logic       pc_src_o;
  logic       flush_o;
  logic [2:0] flags_o;

  typedef struct {
    int         id;
    logic [2:0] we;
    logic       fl;
    logic [2:0] flags;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   sid    = 0;

  always #5 clk = ~clk;

  cond_exec_stage #(.FLUSH_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .stall_i  (stall_i),
    .cond_i   (cond_i),
    .flag_w_i (flag_w_i),
    .reg_w_i  (reg_w_i),
    .mem_w_i  (mem_w_i),
    .pcs_i    (pcs_i),
    .alu_n_i  (alu_n_i),
    .alu_z_i  (alu_z_i),
    .alu_c_i  (alu_c_i),
    .reg_we_o (reg_we_o),
    .mem_we_o (mem_we_o),
    .pc_src_o (pc_src_o),
    .flush_o  (flush_o),
    .flags_o  (flags_o)
  );

  // Monitor: outputs are combinational, so they are settled by negedge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({reg_we_o, mem_we_o, pc_src_o} !== e.we ||
          flush_o !== e.fl || flags_o !== e.flags) begin
        fails++;
        $display("FAIL step%0d: got we=%b flush=%b flags=%b, want we=%b flush=%b flags=%b",
                 e.id, {reg_we_o, mem_we_o, pc_src_o}, flush_o, flags_o,
                 e.we, e.fl, e.flags);
      end
    end
  end

  // in: {rst,valid,stall,reg_w,mem_w,pcs}; alu: {N,Z,C}
  task automatic step(input logic [5:0] in, input logic [3:0] cnd,
                      input logic [1:0] fw, input logic [2:0] alu,
                      input logic chk, input logic [2:0] we,
                      input logic fl, input logic [2:0] flg);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, valid_i, stall_i, reg_w_i, mem_w_i, pcs_i} = in;
    cond_i   = cnd;
    flag_w_i = fw;
    {alu_n_i, alu_z_i, alu_c_i} = alu;
    sid++;
    if (chk) begin
      e.id = sid; e.we = we; e.fl = fl; e.flags = flg;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    {rst, valid_i, stall_i, reg_w_i, mem_w_i, pcs_i} = 6'b110100;
    cond_i = 4'hE; flag_w_i = 2'b00;
    {alu_n_i, alu_z_i, alu_c_i} = 3'b000;
    // reset
    step(6'b110100, 4'hE, 2'b00, 3'b000, 0, 3'b000, 0, 3'b000);
    step(6'b110100, 4'hE, 2'b11, 3'b111, 1, 3'b000, 0, 3'b000);
    // SUBS sets Z, then EQ/NE
    step(6'b010000, 4'hE, 2'b11, 3'b010, 1, 3'b000, 0, 3'b000);
    step(6'b010100, 4'h0, 2'b00, 3'b000, 1, 3'b100, 0, 3'b010);
    step(6'b010100, 4'h1, 2'b00, 3'b000, 1, 3'b000, 0, 3'b010);
    // clear flags, failed conditional flag write, undefined code
    step(6'b010110, 4'hE, 2'b11, 3'b000, 1, 3'b110, 0, 3'b010);
    step(6'b010110, 4'h0, 2'b11, 3'b111, 1, 3'b000, 0, 3'b000);
    step(6'b010110, 4'h6, 2'b11, 3'b111, 1, 3'b000, 0, 3'b000);
    // N=1 C=1: CS/CC/MI/PL/0xF
    step(6'b010000, 4'hE, 2'b11, 3'b101, 1, 3'b000, 0, 3'b000);
    step(6'b010100, 4'h2, 2'b00, 3'b000, 1, 3'b100, 0, 3'b101);
    step(6'b010100, 4'h3, 2'b00, 3'b000, 1, 3'b000, 0, 3'b101);
    step(6'b010010, 4'h4, 2'b00, 3'b000, 1, 3'b010, 0, 3'b101);
    step(6'b010010, 4'h5, 2'b00, 3'b000, 1, 3'b000, 0, 3'b101);
    step(6'b010100, 4'hF, 2'b00, 3'b000, 1, 3'b000, 0, 3'b101);
    // partial flag writes: C only, then NZ only
    step(6'b010000, 4'hE, 2'b01, 3'b010, 1, 3'b000, 0, 3'b101);
    step(6'b010000, 4'hE, 2'b10, 3'b011, 1, 3'b000, 0, 3'b100);
    step(6'b000100, 4'hE, 2'b11, 3'b111, 1, 3'b000, 0, 3'b010);
    // taken branch with flag write, flush, killed second branch
    step(6'b010101, 4'hE, 2'b11, 3'b001, 1, 3'b101, 0, 3'b010);
    step(6'b010100, 4'hE, 2'b00, 3'b000, 1, 3'b000, 1, 3'b001);
    step(6'b010101, 4'hE, 2'b11, 3'b110, 1, 3'b000, 1, 3'b001);
    step(6'b010100, 4'hE, 2'b00, 3'b000, 1, 3'b100, 0, 3'b001);
    // stall during flush holds state and count
    step(6'b010001, 4'hE, 2'b00, 3'b000, 1, 3'b001, 0, 3'b001);
    step(6'b011100, 4'hE, 2'b00, 3'b000, 1, 3'b000, 1, 3'b001);
    step(6'b011100, 4'hE, 2'b00, 3'b000, 1, 3'b000, 1, 3'b001);
    step(6'b011100, 4'hE, 2'b00, 3'b000, 1, 3'b000, 1, 3'b001);
    step(6'b010100, 4'hE, 2'b00, 3'b000, 1, 3'b000, 1, 3'b001);
    step(6'b010100, 4'hE, 2'b00, 3'b000, 1, 3'b000, 1, 3'b001);
    step(6'b010100, 4'hE, 2'b00, 3'b000, 1, 3'b100, 0, 3'b001);
    // stall in idle blocks flag update
    step(6'b011100, 4'hE, 2'b11, 3'b110, 1, 3'b000, 0, 3'b001);
    step(6'b000000, 4'hE, 2'b00, 3'b000, 1, 3'b000, 0, 3'b001);
    // reset in first flush cycle
    step(6'b010001, 4'hE, 2'b11, 3'b101, 1, 3'b001, 0, 3'b001);
    step(6'b110100, 4'hE, 2'b00, 3'b000, 1, 3'b000, 0, 3'b101);
    step(6'b000000, 4'hE, 2'b00, 3'b000, 1, 3'b000, 0, 3'b000);
    step(6'b010001, 4'hE, 2'b00, 3'b000, 1, 3'b001, 0, 3'b000);
    step(6'b000000, 4'hE, 2'b00, 3'b000, 1, 3'b000, 1, 3'b000);
    step(6'b000000, 4'hE, 2'b00, 3'b000, 1, 3'b000, 1, 3'b000);
    step(6'b000000, 4'hE, 2'b00, 3'b000, 1, 3'b000, 0, 3'b000);
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
